// File: rtl/agc_gain_datapath.sv
// AGC datapath: detect-window counters, peak magnitude tracking, level decision
// and the saturating VGA gain code stepped by the controller's adjust phase.
module agc_gain_datapath #(
   parameter int unsigned SAMPLE_W  = 8,
   parameter int unsigned HI_THR    = 96,
   parameter int unsigned LO_THR    = 48,
   parameter int unsigned GAIN_W    = 5,
   parameter int unsigned GAIN_INIT = 16,
   parameter int unsigned GAIN_MAX  = 31
) (
   input  logic                       clk,
   input  logic                       RESETn,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic                       sample_valid,
   input  logic                       counter1_mode,
   input  logic                       counter2_mode,
   input  logic                       preamble_counter_mode,
   input  logic                       detect_mode,
   input  logic                       adjust,
   input  logic                       up_dn,
   output logic [3:0]                 counter1,
   output logic [3:0]                 counter2,
   output logic [7:0]                 preamble_counter,
   output logic                       indicator,
   output logic                       done,
   output logic [GAIN_W-1:0]          gain_code,
   output logic                       gain_at_limit
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned PRE_W = 8;
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(15);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(14);
   localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(127);
   localparam logic [SAMPLE_W-1:0] MAG_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] HI_LVL   = SAMPLE_W'(HI_THR);
   localparam logic [SAMPLE_W-1:0] LO_LVL   = SAMPLE_W'(LO_THR);
   localparam logic [GAIN_W-1:0]   GAIN_TOP = GAIN_W'(GAIN_MAX);
   localparam logic [GAIN_W-1:0]   GAIN_RST = GAIN_W'(GAIN_INIT);

   logic [CNT_W-1:0]    counter1_q, counter1_d;
   logic [CNT_W-1:0]    counter2_q, counter2_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [SAMPLE_W-1:0] peak_q, peak_d;
   logic                indicator_q, indicator_d;
   logic                done_q, done_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic                adjust_q, adjust_d;

   logic [SAMPLE_W-1:0] sample_u;
   logic [SAMPLE_W-1:0] mag;
   logic [SAMPLE_W-1:0] pk;
   logic                win_eval;
   logic                gain_step;

   assign sample_u = sample;

   // Absolute value; the most negative code saturates instead of wrapping.
   always_comb begin
      mag = sample_u;
      if (sample_u == MOST_NEG) begin
         mag = MAG_MAX;
      end else if (sample_u[SAMPLE_W-1]) begin
         mag = ~sample_u + SAMPLE_W'(1);
      end
   end

   assign pk        = (mag > peak_q) ? mag : peak_q;
   assign win_eval  = counter1_mode && sample_valid && (counter1_q == CNT_LAST);
   assign gain_step = adjust && !adjust_q;

   always_comb begin
      counter1_d  = counter1_q;
      counter2_d  = counter2_q;
      pre_d       = pre_q;
      peak_d      = peak_q;
      indicator_d = indicator_q;
      done_d      = done_q;
      gain_d      = gain_q;
      adjust_d    = adjust;

      if (!preamble_counter_mode) begin
         pre_d = '0;
      end else if (sample_valid && (pre_q != PRE_MAX)) begin
         pre_d = pre_q + PRE_W'(1);
      end

      if (!counter1_mode) begin
         counter1_d = '0;
      end else if (sample_valid && (counter1_q != CNT_MAX)) begin
         counter1_d = counter1_q + CNT_W'(1);
      end

      if (!counter2_mode) begin
         counter2_d = '0;
      end else if (counter2_q != CNT_MAX) begin
         counter2_d = counter2_q + CNT_W'(1);
      end

      if (!detect_mode) begin
         peak_d = '0;
      end else if (sample_valid && (counter1_q != CNT_MAX)) begin
         peak_d = pk;
      end

      // Decision lands together with counter1 reaching 15.
      if (win_eval) begin
         indicator_d = (pk >= HI_LVL);
         if ((pk >= LO_LVL) && (pk < HI_LVL)) begin
            done_d = 1'b1;
         end
      end
      if (!preamble_counter_mode) begin
         done_d = 1'b0;
      end

      if (gain_step) begin
         if (up_dn) begin
            if (gain_q != GAIN_TOP) gain_d = gain_q + GAIN_W'(1);
         end else begin
            if (gain_q != '0) gain_d = gain_q - GAIN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!RESETn) begin
         counter1_q  <= '0;
         counter2_q  <= '0;
         pre_q       <= '0;
         peak_q      <= '0;
         indicator_q <= 1'b0;
         done_q      <= 1'b0;
         gain_q      <= GAIN_RST;
         adjust_q    <= 1'b0;
      end else begin
         counter1_q  <= counter1_d;
         counter2_q  <= counter2_d;
         pre_q       <= pre_d;
         peak_q      <= peak_d;
         indicator_q <= indicator_d;
         done_q      <= done_d;
         gain_q      <= gain_d;
         adjust_q    <= adjust_d;
      end
   end

   assign counter1         = counter1_q;
   assign counter2         = counter2_q;
   assign preamble_counter = pre_q;
   assign indicator        = indicator_q;
   assign done             = done_q;
   assign gain_code        = gain_q;
   assign gain_at_limit    = (gain_q == '0) || (gain_q == GAIN_TOP);

endmodule

// File: tb/tb_agc_gain_datapath.sv
// Bench for agc_gain_datapath: directed scenarios plus random traffic, every
// cycle compared against an integer-level reference model.
module tb_agc_gain_datapath;

   logic              clk = 1'b0;
   logic              RESETn;
   logic signed [7:0] sample;
   logic              sample_valid;
   logic              counter1_mode, counter2_mode, preamble_counter_mode;
   logic              detect_mode, adjust, up_dn;
   logic [3:0]        counter1, counter2;
   logic [7:0]        preamble_counter;
   logic              indicator, done, gain_at_limit;
   logic [4:0]        gain_code;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_pre, m_c1, m_c2, m_pk, m_gain;
   bit m_ind, m_done, m_adj;

   agc_gain_datapath dut (
      .clk                   (clk),
      .RESETn                (RESETn),
      .sample                (sample),
      .sample_valid          (sample_valid),
      .counter1_mode         (counter1_mode),
      .counter2_mode         (counter2_mode),
      .preamble_counter_mode (preamble_counter_mode),
      .detect_mode           (detect_mode),
      .adjust                (adjust),
      .up_dn                 (up_dn),
      .counter1              (counter1),
      .counter2              (counter2),
      .preamble_counter      (preamble_counter),
      .indicator             (indicator),
      .done                  (done),
      .gain_code             (gain_code),
      .gain_at_limit         (gain_at_limit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int magf(input logic signed [7:0] s);
      int v;
      v = int'(s);
      if (v < 0) v = -v;
      if (v > 127) v = 127;
      return v;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One clock of the behavioural model, using the inputs present at the edge.
   task automatic model_edge();
      int  pk;
      bit  eval;
      if (!RESETn) begin
         m_pre = 0; m_c1 = 0; m_c2 = 0; m_pk = 0; m_gain = 16;
         m_ind = 0; m_done = 0; m_adj = 0;
         return;
      end
      pk   = imax(m_pk, magf(sample));
      eval = counter1_mode && sample_valid && (m_c1 == 14);
      if (eval) begin
         m_ind = (pk >= 96);
         if (pk >= 48 && pk < 96) m_done = 1;
      end
      if (!preamble_counter_mode) m_done = 0;
      if (!detect_mode) m_pk = 0;
      else if (sample_valid && m_c1 < 15) m_pk = pk;
      if (adjust && !m_adj) m_gain = up_dn ? imin(m_gain + 1, 31) : imax(m_gain - 1, 0);
      m_adj = adjust;
      m_c1  = !counter1_mode ? 0 : (sample_valid ? imin(m_c1 + 1, 15) : m_c1);
      m_c2  = !counter2_mode ? 0 : imin(m_c2 + 1, 15);
      m_pre = !preamble_counter_mode ? 0 : (sample_valid ? imin(m_pre + 1, 127) : m_pre);
   endtask

   task automatic compare_all();
      check("counter1", 32'(counter1), 32'(m_c1));
      check("counter2", 32'(counter2), 32'(m_c2));
      check("preamble_counter", 32'(preamble_counter), 32'(m_pre));
      check("indicator", 32'(indicator), 32'(m_ind));
      check("done", 32'(done), 32'(m_done));
      check("gain_code", 32'(gain_code), 32'(m_gain));
      check("gain_at_limit", 32'(gain_at_limit), 32'((m_gain == 0) || (m_gain == 31)));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic modes(input bit c1, input bit c2, input bit pm, input bit det);
      counter1_mode = c1; counter2_mode = c2; preamble_counter_mode = pm; detect_mode = det;
   endtask

   task automatic push(input logic signed [7:0] s);
      sample = s; sample_valid = 1'b1;
      cyc();
      sample_valid = 1'b0;
   endtask

   task automatic clear_all();
      modes(0, 0, 0, 0);
      sample_valid = 1'b0; adjust = 1'b0;
      cyc();
   endtask

   initial begin
      RESETn = 1'b0; sample = '0; sample_valid = 1'b0; adjust = 1'b0; up_dn = 1'b0;
      modes(0, 0, 0, 0);
      repeat (3) cyc();
      RESETn = 1'b1;
      cyc();
      check("rst_gain", 32'(gain_code), 32'd16);
      check("rst_limit", 32'(gain_at_limit), 32'd0);
      check("rst_c1", 32'(counter1), 32'd0);
      check("rst_ind", 32'(indicator), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      // loud window
      modes(1, 0, 1, 1);
      for (int i = 0; i < 15; i++) push((i % 2) ? -8'sd100 : 8'sd100);
      check("loud_c1", 32'(counter1), 32'd15);
      check("loud_ind", 32'(indicator), 32'd1);
      check("loud_done", 32'(done), 32'd0);
      check("loud_pre", 32'(preamble_counter), 32'd15);

      // in-range window, peak 60
      clear_all();
      modes(1, 0, 1, 1);
      for (int i = 0; i < 15; i++) push((i == 1) ? 8'sd60 : ((i % 2) ? 8'sd20 : 8'sd10));
      check("mid_ind", 32'(indicator), 32'd0);
      check("mid_done", 32'(done), 32'd1);
      detect_mode = 1'b0;
      repeat (3) cyc();
      check("done_sticky", 32'(done), 32'd1);
      preamble_counter_mode = 1'b0;
      cyc();
      check("done_clear", 32'(done), 32'd0);

      // most negative sample alone, then preamble saturation
      clear_all();
      modes(1, 0, 1, 1);
      push(-8'sd128);
      for (int i = 0; i < 14; i++) push(8'sd0);
      check("neg_ind", 32'(indicator), 32'd1);
      for (int i = 0; i < 200; i++) push(8'($urandom_range(0, 255)));
      check("pre_sat", 32'(preamble_counter), 32'd127);

      // held adjust steps exactly once
      clear_all();
      modes(0, 1, 0, 0);
      up_dn = 1'b1; adjust = 1'b1;
      repeat (16) cyc();
      check("adj_up", 32'(gain_code), 32'd17);
      check("c2_sat", 32'(counter2), 32'd15);
      adjust = 1'b0; cyc();
      up_dn = 1'b0; adjust = 1'b1;
      repeat (16) cyc();
      check("adj_dn", 32'(gain_code), 32'd16);
      adjust = 1'b0; cyc();

      // saturate at GAIN_MAX, then reset mid-adjust
      up_dn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         adjust = 1'b1; cyc();
         adjust = 1'b0; cyc();
      end
      check("gain_max", 32'(gain_code), 32'd31);
      check("gain_lim", 32'(gain_at_limit), 32'd1);
      adjust = 1'b1; cyc();
      RESETn = 1'b0; cyc();
      check("rst_adj", 32'(gain_code), 32'd16);
      RESETn = 1'b1; adjust = 1'b0; cyc();

      // saturate at 0
      up_dn = 1'b0;
      for (int i = 0; i < 18; i++) begin
         adjust = 1'b1; cyc();
         adjust = 1'b0; cyc();
      end
      check("gain_min", 32'(gain_code), 32'd0);
      check("gain_min_lim", 32'(gain_at_limit), 32'd1);

      // random traffic, modes mostly on so windows complete
      for (int i = 0; i < 4000; i++) begin
         RESETn                = ($urandom_range(0, 199) != 0);
         sample                = 8'($urandom);
         sample_valid          = ($urandom_range(0, 3) != 0);
         counter1_mode         = ($urandom_range(0, 24) != 0);
         counter2_mode         = ($urandom_range(0, 9) != 0);
         preamble_counter_mode = ($urandom_range(0, 49) != 0);
         detect_mode           = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 5) == 0) adjust = ~adjust;
         up_dn                 = ($urandom_range(0, 1) == 1);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/agc_gain_datapath.md
Name: agc_gain_datapath

Overview:
- Counterpart of the AGC state-machine controller. It supplies the counters, the level indicator and the done flag, and consumes the controller's mode, adjust and direction outputs.
- Measures ADC sample magnitude over detect windows, decides too-loud or in-range, and owns the gain code driven to the analog VGA.
- Sits between the ADC sample stream and the VGA gain bus, with a point-to-point link to the controller.

Parameters:
- SAMPLE_W, 8: ADC sample width, two's complement.
- HI_THR, 96: peak magnitude at or above this means too loud.
- LO_THR, 48: peak magnitude at or above this, and below HI_THR, means in range.
- GAIN_W, 5: width of the gain code.
- GAIN_INIT, 16: gain code after reset.
- GAIN_MAX, 31: upper saturation limit of the gain code.

Ports:
- clk  in  1  system clock
- RESETn  in  1  synchronous, active-low reset
- sample  in  SAMPLE_W  signed ADC sample
- sample_valid  in  1  sample qualifier, one per cycle max
- counter1_mode  in  1  enable for counter1 (detect window)
- counter2_mode  in  1  enable for counter2 (settle timer)
- preamble_counter_mode  in  1  enable for preamble counter; 0 = clear
- detect_mode  in  1  peak tracking enable
- adjust  in  1  controller is in its adjust phase (level, multi-cycle)
- up_dn  in  1  1 = gain up, 0 = gain down
- counter1  out  4  detect window sample count
- counter2  out  4  settle cycle count
- preamble_counter  out  8  preamble sample count
- indicator  out  1  last window was too loud
- done  out  1  sticky: signal in range
- gain_code  out  GAIN_W  VGA gain setting
- gain_at_limit  out  1  gain_code is 0 or GAIN_MAX

Behaviour:
- Reset (RESETn=0 at a clk edge): all counters = 0, indicator = 0, done = 0, gain_code = GAIN_INIT, peak = 0, adjust_d = 0.
  - Reset mid-window or mid-adjust discards all progress; no partial step is applied.
- preamble_counter:
  - preamble_counter_mode=0: clear to 0 next edge.
  - Otherwise +1 per sample_valid, saturating at 127 (never wraps).
- counter1:
  - counter1_mode=0: clear.
  - Otherwise +1 per sample_valid while below 15, then holds at 15.
  - Samples arriving at 15 are ignored for peak tracking.
- counter2:
  - counter2_mode=0: clear.
  - Otherwise +1 every clk, with no sample qualifier, saturating at 15.
- Magnitude: |sample|, computed at SAMPLE_W bits. The most negative code maps to 2^(SAMPLE_W-1)-1 (saturated, no overflow).
- Peak:
  - Cleared whenever detect_mode=0.
  - While detect_mode=1, sample_valid=1 and counter1<15: peak <= max(peak, mag).
- Window evaluation, on the same edge counter1 steps 14->15, using max(peak, current mag):
  - indicator <= (pk >= HI_THR).
  - done set if LO_THR <= pk < HI_THR.
  - Registered alongside counter1=15, so the controller sees both in the same cycle.
  - Outside evaluation edges, indicator holds.
  - done is sticky; it clears only on reset or on preamble_counter_mode=0.
- Gain step:
  - adjust_d registers adjust each cycle.
  - Exactly one step occurs on the cycle adjust=1 and adjust_d=0 (rising edge), regardless of how long adjust stays high.
  - up_dn=1: gain_code+1, saturating at GAIN_MAX. up_dn=0: gain_code-1, saturating at 0.
  - Latency: new gain_code visible one cycle after the first adjust=1 cycle.
- gain_at_limit: combinational from gain_code.
- Simultaneous events:
  - A clear (mode=0) beats an increment.
  - A window evaluation with done=0 does not clear an already-set done.
  - A gain step and a window evaluation in the same cycle are independent.
- No data registering on sample beyond the peak register; all outputs are registered except gain_at_limit.

Test Plan:
- Reset, then release RESETn with all modes 0 -> gain_code=16, gain_at_limit=0, counters=0, indicator=0, done=0.
- detect_mode=counter1_mode=preamble_counter_mode=1, 15 valid samples of magnitude 100 -> counter1=15 and indicator=1 on the 15th sample's edge, done=0, preamble_counter=15.
- Same setup with magnitudes 10,60,20,... (peak 60) -> indicator=0 and done=1 at counter1=15. done stays 1 after detect_mode drops and clears when preamble_counter_mode=0.
- Sample -128 alone in a window -> mag 127, indicator=1. 200 valid samples -> preamble_counter saturates at 127.
- adjust held high for 16 cycles with up_dn=1 and counter2_mode=1 -> gain_code 16->17 once, counter2 holds at 15. Repeat with up_dn=0 -> back to 16.
- gain_code=31, adjust pulse with up_dn=1 -> stays 31, gain_at_limit=1. RESETn low during adjust -> gain_code=16 on the next edge.
